// File: rtl/friscv_memfy_loadwb.sv
// Load write-back stage: tracks in-order load descriptors, formats each read
// response and issues one registered register-file write (or an error pulse).
module friscv_memfy_loadwb #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_rd_addr,
    input  logic [2:0]        req_funct3,
    input  logic [1:0]        req_offset,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [XLEN-1:0]   rsp_data,
    input  logic [1:0]        rsp_resp,
    output logic              memfy_rd_wr,
    output logic [4:0]        memfy_rd_addr,
    output logic [XLEN-1:0]   memfy_rd_val,
    output logic [XLEN/8-1:0] memfy_rd_strb,
    output logic [31:0]       pending_mask,
    output logic              load_err
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic [4:0] rd_mem  [DEPTH];
    logic [2:0] f3_mem  [DEPTH];
    logic [1:0] off_mem [DEPTH];

    logic push;
    logic pop;

    assign req_ready = (count_reg != (AW+1)'(DEPTH));
    assign rsp_ready = (count_reg != '0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    // Entry contents need no reset: occupancy is derived from pointers and count.
    always_ff @(posedge aclk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]  <= req_rd_addr;
            f3_mem[wr_ptr_reg]  <= req_funct3;
            off_mem[wr_ptr_reg] <= req_offset;
        end
    end

    logic [4:0]      head_rd;
    logic [2:0]      head_f3;
    logic [1:0]      head_off;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] fmt_val;
    logic            fmt_err;
    logic            wr_next;
    logic            err_next;

    assign head_rd  = rd_mem[rd_ptr_reg];
    assign head_f3  = f3_mem[rd_ptr_reg];
    assign head_off = off_mem[rd_ptr_reg];
    assign byte_sel = 8'(rsp_data >> {head_off, 3'b000});
    assign half_sel = 16'(rsp_data >> {head_off[1], 4'b0000});

    always_comb begin
        fmt_val = rsp_data;
        fmt_err = (rsp_resp != 2'b00);
        case (head_f3)
            3'b000: fmt_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100: fmt_val = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001: begin
                fmt_val = {{(XLEN-16){half_sel[15]}}, half_sel};
                fmt_err = fmt_err || head_off[0];
            end
            3'b101: begin
                fmt_val = {{(XLEN-16){1'b0}}, half_sel};
                fmt_err = fmt_err || head_off[0];
            end
            3'b010: fmt_err = fmt_err || (head_off != 2'b00);
            default: fmt_err = 1'b1;
        endcase
    end

    // Loads to x0 are retired silently: neither a write nor an error.
    assign wr_next  = pop && !fmt_err && (head_rd != 5'd0);
    assign err_next = pop &&  fmt_err && (head_rd != 5'd0);

    always_ff @(posedge aclk) begin
        if (srst) begin
            memfy_rd_wr   <= 1'b0;
            memfy_rd_addr <= '0;
            memfy_rd_val  <= '0;
            memfy_rd_strb <= '0;
            load_err      <= 1'b0;
        end else begin
            memfy_rd_wr   <= wr_next;
            memfy_rd_strb <= wr_next ? '1 : '0;
            load_err      <= err_next;
            if (pop) begin
                memfy_rd_addr <= head_rd;
                memfy_rd_val  <= fmt_val;
            end
        end
    end

    logic [DEPTH-1:0] occupied;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
            logic [AW-1:0] rel;
            assign rel          = AW'(gi) - rd_ptr_reg;
            assign occupied[gi] = ({1'b0, rel} < count_reg);
        end
    endgenerate

    always_comb begin
        pending_mask = '0;
        for (int e = 0; e < DEPTH; e++)
            if (occupied[e])
                pending_mask[rd_mem[e]] = 1'b1;
        if (memfy_rd_wr)
            pending_mask[memfy_rd_addr] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_friscv_memfy_loadwb.sv
// Randomized self-checking bench for friscv_memfy_loadwb against a queue-based
// model of the descriptor tracker and the load formatting rules.
module tb_friscv_memfy_loadwb;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            aclk = 1'b0;
    logic            srst;
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_rd_addr;
    logic [2:0]      req_funct3;
    logic [1:0]      req_offset;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_resp;
    logic            memfy_rd_wr;
    logic [4:0]      memfy_rd_addr;
    logic [31:0]     memfy_rd_val;
    logic [3:0]      memfy_rd_strb;
    logic [31:0]     pending_mask;
    logic            load_err;

    friscv_memfy_loadwb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .srst          (srst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd_addr   (req_rd_addr),
        .req_funct3    (req_funct3),
        .req_offset    (req_offset),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_resp      (rsp_resp),
        .memfy_rd_wr   (memfy_rd_wr),
        .memfy_rd_addr (memfy_rd_addr),
        .memfy_rd_val  (memfy_rd_val),
        .memfy_rd_strb (memfy_rd_strb),
        .pending_mask  (pending_mask),
        .load_err      (load_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } desc_t;

    desc_t       q[$];
    logic        exp_wr;
    logic        exp_err;
    logic [4:0]  exp_addr;
    logic [31:0] exp_val;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural meaning of a RISC-V load, expressed with shifts and masks.
    task automatic model_load(input desc_t d, input logic [31:0] data, input logic [1:0] resp,
                              output logic wr, output logic err, output logic [31:0] val);
        logic [31:0] b;
        logic [31:0] h;
        logic        bad;
        b   = (data >> (d.off * 8)) & 32'hFF;
        h   = (data >> (d.off[1] * 16)) & 32'hFFFF;
        bad = (resp != 0);
        val = data;
        case (d.f3)
            3'd0: val = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd4: val = b;
            3'd1: begin val = (h >= 32768) ? (h | 32'hFFFF_0000) : h; bad = bad || (d.off % 2 == 1); end
            3'd5: begin val = h; bad = bad || (d.off % 2 == 1); end
            3'd2: bad = bad || (d.off != 0);
            default: bad = 1'b1;
        endcase
        wr  = !bad && d.rd != 0;
        err =  bad && d.rd != 0;
    endtask

    task automatic step(input logic rv, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] off, input logic sv, input logic [31:0] data,
                        input logic [1:0] resp, input logic rst);
        desc_t       d;
        logic        do_push;
        logic        do_pop;
        logic [31:0] exp_pend;
        srst        = rst;
        req_valid   = rv;
        req_rd_addr = rd;
        req_funct3  = f3;
        req_offset  = off;
        rsp_valid   = sv;
        rsp_data    = data;
        rsp_resp    = resp;
        exp_wr      = 1'b0;
        exp_err     = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            do_push = rv && (q.size() < DEPTH);
            do_pop  = sv && (q.size() > 0);
            if (do_pop) begin
                d = q.pop_front();
                model_load(d, data, resp, exp_wr, exp_err, exp_val);
                exp_addr = d.rd;
                $display("load rd=x%0d f3=%0d off=%0d data=%h resp=%0d -> wr=%0b err=%0b val=%h",
                         d.rd, d.f3, d.off, data, resp, exp_wr, exp_err, exp_val);
            end
            if (do_push) begin
                d.rd = rd; d.f3 = f3; d.off = off;
                q.push_back(d);
            end
        end
        @(posedge aclk);
        #1;
        exp_pend = 32'd0;
        foreach (q[i]) exp_pend[q[i].rd] = 1'b1;
        if (exp_wr) exp_pend[exp_addr] = 1'b1;
        exp_pend[0] = 1'b0;
        check("memfy_rd_wr", {31'd0, memfy_rd_wr}, {31'd0, exp_wr});
        check("load_err", {31'd0, load_err}, {31'd0, exp_err});
        check("pending_mask", pending_mask, exp_pend);
        check("req_ready", {31'd0, req_ready}, {31'd0, q.size() != DEPTH});
        check("rsp_ready", {31'd0, rsp_ready}, {31'd0, q.size() != 0});
        if (exp_wr) begin
            check("memfy_rd_addr", {27'd0, memfy_rd_addr}, {27'd0, exp_addr});
            check("memfy_rd_val", memfy_rd_val, exp_val);
            check("memfy_rd_strb", {28'd0, memfy_rd_strb}, 32'hF);
        end
    endtask

    task automatic push_req(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        step(1'b1, rd, f3, off, 1'b0, 32'd0, 2'd0, 1'b0);
    endtask

    task automatic send_rsp(input logic [31:0] data, input logic [1:0] resp);
        step(1'b0, 5'd0, 3'd0, 2'd0, 1'b1, data, resp, 1'b0);
    endtask

    initial begin
        step(1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 2'd0, 1'b1);
        step(1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h1234_5678, 2'd0, 1'b1);
        check("reset_val", memfy_rd_val, 32'd0);
        check("reset_addr", {27'd0, memfy_rd_addr}, 32'd0);
        check("reset_strb", {28'd0, memfy_rd_strb}, 32'd0);
        // Response with nothing outstanding must stall.
        send_rsp(32'hAAAA_AAAA, 2'd0);

        push_req(5'd5, 3'd2, 2'd0);
        send_rsp(32'hDEAD_BEEF, 2'd0);
        check("lw_x5_val", memfy_rd_val, 32'hDEAD_BEEF);

        push_req(5'd6, 3'd0, 2'd3);
        push_req(5'd7, 3'd4, 2'd3);
        send_rsp(32'h8011_2233, 2'd0);
        check("lb_x6_val", memfy_rd_val, 32'hFFFF_FF80);
        send_rsp(32'h8011_2233, 2'd0);
        check("lbu_x7_val", memfy_rd_val, 32'h0000_0080);

        for (int r = 1; r <= 4; r++) push_req(5'(r), 3'd2, 2'd0);
        check("full_req_ready", {31'd0, req_ready}, 32'd0);
        check("full_pending", pending_mask, 32'h0000_001E);
        push_req(5'd9, 3'd2, 2'd0);
        for (int r = 1; r <= 4; r++) send_rsp(32'h100 * r, 2'd0);
        step(1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'd0, 2'd0, 1'b0);
        check("drained_pending", pending_mask, 32'd0);

        push_req(5'd8, 3'd1, 2'd1);
        push_req(5'd9, 3'd2, 2'd0);
        send_rsp(32'h5555_6666, 2'd0);
        check("lh_misaligned_err", {31'd0, load_err}, 32'd1);
        send_rsp(32'h7777_8888, 2'd2);
        check("lw_slverr_err", {31'd0, load_err}, 32'd1);
        check("err_pending", pending_mask, 32'd0);

        push_req(5'd0, 3'd2, 2'd0);
        check("x0_pending", pending_mask, 32'd0);
        send_rsp(32'hCAFE_F00D, 2'd0);

        for (int r = 10; r < 13; r++) push_req(5'(r), 3'd4, 2'(r));
        step(1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'h1111_2222, 2'd0, 1'b1);
        check("flush_pending", pending_mask, 32'd0);
        check("flush_rsp_ready", {31'd0, rsp_ready}, 32'd0);
        send_rsp(32'h3333_4444, 2'd0);

        for (int c = 0; c < 3000; c++) begin
            logic [2:0] f3;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2) == 0 ? 2 : ($urandom_range(0, 1) ? 0 : 1) | ($urandom_range(0, 1) ? 4 : 0));
            step($urandom_range(0, 1) == 1,
                 5'($urandom_range(1, 31)),
                 f3,
                 2'($urandom),
                 $urandom_range(0, 2) != 0,
                 $urandom,
                 ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                 $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/friscv_memfy_loadwb.md
# friscv_memfy_loadwb

Load write-back stage between the data-memory read channel and the register file's memfy write port. It queues in-order load descriptors, matches each read response to the oldest descriptor, and extracts/extends the loaded byte, half or word. It then issues one registered full-word write to the destination register. It also exports a per-register pending mask so the issuing logic can stall on RAW hazards against outstanding loads.

## Interface
- XLEN, 32, data width; only 32 supported
- DEPTH, 4, outstanding-load capacity; power of two, >= 2
- aclk  in  1  clock; one clock, all logic on rising edge
- srst  in  1  reset; synchronous, active-high
- req_valid  in  1  load descriptor valid
- req_ready  out  1  descriptor accepted when valid & ready
- req_rd_addr  in  5  destination register
- req_funct3  in  3  load funct3 (LB/LH/LW/LBU/LHU)
- req_offset  in  2  byte address bits [1:0]
- rsp_valid  in  1  read data valid
- rsp_ready  out  1  read data accepted when valid & ready
- rsp_data  in  XLEN  read word (aligned)
- rsp_resp  in  2  AXI-style response; 0 = OKAY
- memfy_rd_wr  out  1  register write strobe
- memfy_rd_addr  out  5  register index
- memfy_rd_val  out  XLEN  formatted value
- memfy_rd_strb  out  XLEN/8  byte enables; all ones whenever memfy_rd_wr is high
- pending_mask  out  32  bit i set = write to xi outstanding
- load_err  out  1  one-cycle error pulse

## Operation
- Tracking FIFO: DEPTH entries of {rd, funct3, offset}; write/read pointers plus count, wrap modulo DEPTH.
- Handshakes: req_ready = (count != DEPTH); rsp_ready = (count != 0). Both come from registered count only and never depend on req_valid or rsp_valid.
- Push and pop in the same cycle:
  - Count is unchanged.
  - When the FIFO is full, no push occurs even if a pop happens that cycle.
- A response arriving while the FIFO is empty is stalled (rsp_ready low) and is not dropped.
- Formatting on pop, using the head entry and rsp_data:
  - LB (000): rsp_data[offset*8+:8], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): rsp_data[offset[1]*16+:16], sign-extended.
  - LHU (101): same halfword, zero-extended.
  - LW (010): rsp_data unchanged.
- Error, raised on pop when any of the following holds:
  - rsp_resp != 0;
  - funct3 not in the set above;
  - LH/LHU with offset[0] = 1;
  - LW with offset != 0.
- On error: load_err pulses, memfy_rd_wr stays low, and the entry is still popped.
- rd = 0: entry popped, no write, no error.
- pending_mask: bit i = OR over occupied entries with rd == i, OR (memfy_rd_wr && memfy_rd_addr == i). Bit 0 is always 0. Duplicate rds in flight keep the bit set until the last matching write.

## Timing
- Reset values: pointers, count, memfy_rd_wr, memfy_rd_addr, memfy_rd_val, memfy_rd_strb and load_err = 0. req_ready = 1, rsp_ready = 0, pending_mask = 0.
- Descriptor visibility: a descriptor accepted in cycle N sets its pending_mask bit in cycle N+1 and can be popped from cycle N+1 onward.
- Write latency: a response handshake in cycle N produces memfy_rd_wr/addr/val/strb (or load_err) registered in cycle N+1, high for exactly one cycle. Back-to-back responses produce back-to-back writes.
- pending_mask bit for the popped rd:
  - with a write: stays set through cycle N+1 and clears in N+2, unless another entry targets the same rd;
  - error or rd = 0: clears in N+1.
- srst mid-operation flushes all entries in the next cycle. Any response data still in flight afterward is stalled as if the FIFO were empty. No write or error issues in the cycle after srst.

## Test plan
- LW to x5, offset 0, data 0xDEADBEEF -> one cycle after the response: memfy_rd_wr = 1, addr = 5, val = 0xDEADBEEF, strb = 0xF.
- LB to x6 with offset 3 and data 0x80112233, then LBU to x7 with the same offset and data -> x6 gets 0xFFFFFF80, x7 gets 0x00000080 on consecutive cycles.
- Push 4 loads (x1..x4) with no responses -> req_ready goes low on the 4th accept and pending_mask = 0x0000001E. Return 4 responses -> writes in order x1..x4 and pending_mask returns to 0.
- LH to x8 with offset 1 -> load_err pulses and no write. LW to x9 with rsp_resp = 2 -> load_err pulses and no write. pending_mask bits 8 and 9 clear.
- LW to x0 -> entry popped, no write, no error, pending_mask bit 0 stays 0.
- Assert srst with 3 entries queued -> next cycle count = 0, rsp_ready = 0, pending_mask = 0, no memfy_rd_wr.
